// File: rtl/icache_line_fill.sv
// icache_line_fill: fetches one 8-word instruction-cache line over a req/gnt/rvalid port.
// Build option: define ICACHE_FILL_CWF_EN for critical-word-first order and the crit_* outputs.
//
// state | meaning
// IDLE  | waiting for miss_req
// FILL  | issuing reads and collecting in-order responses
// DONE  | single-cycle line_valid, w0..w7 carry the new line
// DRAIN | flushed; discarding responses of reads already granted
module icache_line_fill #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       w0,
    output logic [31:0]       w1,
    output logic [31:0]       w2,
    output logic [31:0]       w3,
    output logic [31:0]       w4,
    output logic [31:0]       w5,
    output logic [31:0]       w6,
    output logic [31:0]       w7,
    output logic [ADDR_W-1:0] line_addr,
    output logic              line_valid,
    output logic              busy,
    output logic              crit_valid,
    output logic [31:0]       crit_data
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam int OFF_W = IDX_W + 2;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE, S_DRAIN} state_t;

    state_t            state;
    logic [IDX_W-1:0]  start;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic [31:0]       fill_buf [LINE_WORDS];
    logic [31:0]       line_q   [LINE_WORDS];

    logic              issue_fire;
    logic              resp_take;
    logic [CNT_W-1:0]  issue_nxt;
    logic [CNT_W-1:0]  recv_nxt;
    logic [IDX_W-1:0]  recv_idx;
    logic [IDX_W-1:0]  issue_idx_nxt;
    logic [IDX_W-1:0]  miss_start;
    logic [ADDR_W-1:0] miss_base;
    logic              unused_addr_bits;

    function automatic logic [ADDR_W-1:0] word_off(input logic [IDX_W-1:0] idx);
        return {{(ADDR_W-OFF_W){1'b0}}, idx, 2'b00};
    endfunction

    assign miss_base = {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
`ifdef ICACHE_FILL_CWF_EN
    assign miss_start = miss_addr[OFF_W-1:2];
`else
    assign miss_start = '0;
`endif
    assign unused_addr_bits = ^miss_addr[OFF_W-1:0];

    // A response only counts while a granted read is still outstanding.
    assign issue_fire    = mem_req && mem_gnt;
    assign resp_take     = mem_rvalid && (state == S_FILL || state == S_DRAIN)
                           && (recv_cnt != issue_cnt);
    assign issue_nxt     = issue_cnt + CNT_W'(issue_fire);
    assign recv_nxt      = recv_cnt + CNT_W'(resp_take);
    assign recv_idx      = start + recv_cnt[IDX_W-1:0];
    assign issue_idx_nxt = start + issue_nxt[IDX_W-1:0];

    assign busy = (state != S_IDLE);
    assign w0 = line_q[0];
    assign w1 = line_q[1];
    assign w2 = line_q[2];
    assign w3 = line_q[3];
    assign w4 = line_q[4];
    assign w5 = line_q[5];
    assign w6 = line_q[6];
    assign w7 = line_q[7];

`ifdef ICACHE_FILL_CWF_EN
    logic        crit_valid_q;
    logic [31:0] crit_data_q;
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;
`else
    assign crit_valid = 1'b0;
    assign crit_data  = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            start      <= '0;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            line_addr  <= '0;
            line_valid <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                fill_buf[i] <= '0;
                line_q[i]   <= '0;
            end
`ifdef ICACHE_FILL_CWF_EN
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
`endif
        end else begin
            line_valid <= 1'b0;
`ifdef ICACHE_FILL_CWF_EN
            crit_valid_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (miss_req) begin
                        state     <= S_FILL;
                        line_addr <= miss_base;
                        start     <= miss_start;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        mem_req   <= 1'b1;
                        mem_addr  <= miss_base | word_off(miss_start);
                    end
                end
                S_FILL: begin
                    issue_cnt <= issue_nxt;
                    recv_cnt  <= recv_nxt;
                    mem_req   <= !flush && (issue_nxt < CNT_FULL);
                    if (issue_fire) begin
                        mem_addr <= line_addr | word_off(issue_idx_nxt);
                    end
                    if (resp_take) begin
                        fill_buf[recv_idx] <= mem_rdata;
                    end
`ifdef ICACHE_FILL_CWF_EN
                    if (resp_take && recv_cnt == '0 && !flush) begin
                        crit_valid_q <= 1'b1;
                        crit_data_q  <= mem_rdata;
                    end
`endif
                    // Flush beats completion, even on the last response.
                    if (flush) begin
                        state <= (recv_nxt == issue_nxt) ? S_IDLE : S_DRAIN;
                    end else if (recv_nxt == CNT_FULL) begin
                        state      <= S_DONE;
                        line_valid <= 1'b1;
                        for (int i = 0; i < LINE_WORDS; i++) begin
                            line_q[i] <= (IDX_W'(i) == recv_idx) ? mem_rdata : fill_buf[i];
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                S_DRAIN: begin
                    mem_req  <= 1'b0;
                    recv_cnt <= recv_nxt;
                    if (recv_nxt == issue_cnt) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/icache_line_fill.md
# icache_line_fill

Line-refill engine between the word-wide instruction backing memory and the 16×8-word instruction cache. On a cache miss it fetches the eight 32-bit words of the missing line through a request/grant/response memory port, with up to eight reads outstanding, and assembles them in order. It then presents the whole line as `w0`..`w7` with a one-cycle `line_valid` pulse, which drives the cache's `update` write. `busy` feeds the fetch-stage PC stall.

## Interface
Parameters:
- `LINE_WORDS`, 8: words per line; fixed at 8, with index width 3.
- `ADDR_W`, 32: address width.

Ports:
- `CLK` in 1: clock; all state changes on posedge.
- `RST` in 1: synchronous, active-high reset.
- `miss_req` in 1: fill request, sampled only in IDLE.
- `miss_addr` in 32: faulting PC, byte address.
- `flush` in 1: abort the current fill.
- `mem_req` out 1: read request valid.
- `mem_addr` out 32: word-aligned read address.
- `mem_gnt` in 1: the request is accepted when `mem_req && mem_gnt`.
- `mem_rvalid` in 1: read data valid; responses return in request order.
- `mem_rdata` in 32: read data.
- `w0`..`w7` out 32 each: assembled line words, indexed by word offset.
- `line_addr` out 32: line base, `{miss_addr[31:5],5'b0}`.
- `line_valid` out 1: one-cycle pulse when the line is complete.
- `busy` out 1: high whenever state != IDLE.
- `crit_valid` out 1, `crit_data` out 32: early critical word (see Configuration).

## Operation
- States:
  - IDLE: on `miss_req` → FILL; latch `line_addr`, set `start` = 0, or `miss_addr[4:2]` under the macro; clear `issue_cnt` and `recv_cnt` (4 bits each).
  - FILL:
    - `mem_req` = (`issue_cnt` < 8).
    - `mem_addr` = `line_addr + {((start+issue_cnt) mod 8), 2'b00}`.
    - Each grant increments `issue_cnt`.
    - Each `mem_rvalid` writes `mem_rdata` into word `(start+recv_cnt) mod 8`, then increments `recv_cnt`.
    - When `recv_cnt` reaches 8 → DONE.
  - DONE: `line_valid` = 1 for this single cycle → IDLE.
  - DRAIN: entered on `flush` in FILL. `mem_req` = 0. Responses for already-granted reads are discarded. When `recv_cnt == issue_cnt` → IDLE. No `line_valid`.
- The index wrap is 3-bit modulo; `line_addr` never increments across the line boundary.
- `w0`..`w7` hold their values from DONE until overwritten by the next fill.
- Simultaneous events:
  - Grant and response in the same cycle: both counters update.
  - `flush` in the cycle of the 8th response: flush wins → IDLE via DRAIN rules (already drained). No `line_valid`.
  - `flush` in IDLE or DONE: ignored; the DONE pulse still occurs.
  - `miss_req` outside IDLE: ignored.
- `mem_rvalid` in IDLE, or with `recv_cnt == issue_cnt`: ignored, no state change.

## Timing
- Reset values:
  - State IDLE.
  - `mem_req`, `line_valid`, `busy`, `crit_valid` = 0.
  - `mem_addr`, `line_addr`, `crit_data`, `w0`..`w7` = 0.
  - Counters 0.
- Reset mid-fill drops everything next cycle. Memory responses still in flight afterwards are ignored in IDLE; the memory side must also be reset.
- `miss_req` sampled at edge N → `busy` and `mem_req` high from cycle N+1.
- Zero-wait memory: grant every cycle, response one cycle after grant.
  - Issues in cycles N+1..N+8, responses in N+2..N+9, DONE (`line_valid`) at N+10, IDLE at N+11.
  - A new `miss_req` can be accepted at edge N+11.
- `mem_req` is a registered-state function; while `mem_req` is high and `mem_gnt` is low, `mem_addr` is held stable.
- All outputs are registered or decoded from registered state only; there is no combinational input→output path.

## Configuration
- `ICACHE_FILL_CWF_EN` defined (critical-word-first):
  - `start` = `miss_addr[4:2]`; the fetch order wraps from the critical word.
  - `crit_valid` pulses for one cycle, in the cycle after the first response, with `crit_data` equal to that word.
- Not defined:
  - `start` = 0, order 0..7.
  - `crit_valid` and `crit_data` are tied to 0.
- Fill latency is identical in both builds.

## Test plan
- Reset, then `miss_req` with `miss_addr`=0x0000_0124, zero-wait memory → `mem_addr` sequence 0x120..0x13C. `line_valid` exactly at N+10 with `line_addr`=0x120. `w3` = data returned for 0x12C.
- Random `mem_gnt` stalls (≈50%) and response delay of 1–4 cycles → `mem_addr` held during stalls, exactly 8 grants, words land at the correct offsets, single `line_valid`.
- `flush` after 3 grants and 1 response → `mem_req` drops the next cycle, 2 further responses discarded, IDLE after the last one, no `line_valid`, `w*` unchanged from the previous line.
- `RST` asserted at cycle N+5 of a fill → next cycle all outputs 0 and state IDLE; stray `mem_rvalid` afterwards causes no change.
- With `ICACHE_FILL_CWF_EN`, `miss_addr`=0x0000_0218 → addresses 0x218, 0x21C, 0x200..0x214. `crit_valid` on the cycle after the first response with `crit_data` = word for 0x218. Line contents identical to the non-CWF build.
- `miss_req` held high across DONE → `line_valid` is one cycle only, and a second fill starts from IDLE the cycle after.
